// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM handshake state and arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: dcache has priority,
// icache is forced in after STARVE_MAX back-to-back dcache completions.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int unsigned SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          d_req;

  assign d_req = dREN | dWEN;

  // arbiter state register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // icache starvation counter
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // next state, starvation update and RAM-side strobes
  always_comb begin
    state_d  = state_q;
    starve_d = iREN ? starve_q : '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = ramload;
    dload    = ramload;

    case (state_q)
      ARB: begin
        if ((starve_q == STARVE_LIM) && iREN) begin
          state_d = IGRANT;
        end else if (d_req) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end else begin
          state_d = ARB;
        end
      end

      DGRANT: begin
        if (!d_req) begin
          state_d = ARB;
        end else begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          case (ramstate)
            ACCESS: begin
              dwait = 1'b0;
              if (iREN) begin
                starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + SW'(1);
              end else begin
                starve_d = '0;
              end
              // burst continuation unless the icache has waited long enough
              if (iREN && (starve_d == STARVE_LIM)) begin
                state_d = IGRANT;
              end else begin
                state_d = DGRANT;
              end
            end
            ERROR:   state_d = ARB;
            default: state_d = DGRANT;
          endcase
        end
      end

      IGRANT: begin
        if (!iREN) begin
          state_d = ARB;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          case (ramstate)
            ACCESS: begin
              iwait    = 1'b0;
              starve_d = '0;
              state_d  = IGRANT;
            end
            ERROR:   state_d = ARB;
            default: state_d = IGRANT;
          endcase
        end
      end

      default: state_d = ARB;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// transaction-owner model of the arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int SMAX = 4;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore, ramload;
  logic      iwait, dwait, ramREN, ramWEN;
  word_t     iload, dload, ramaddr, ramstore;
  ramstate_t ramstate;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // model: who currently owns the RAM (0 nobody, 1 dcache, 2 icache)
  int m_owner;
  int m_starve;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // compare all outputs against the model at the falling edge
  task automatic sample();
    logic        e_iw, e_dw, e_rr, e_rw;
    logic [31:0] e_a, e_s;
    @(negedge CLK);
    e_iw = 1'b1; e_dw = 1'b1; e_rr = 1'b0; e_rw = 1'b0; e_a = 32'h0; e_s = 32'h0;
    if (m_owner == 1 && (dREN || dWEN)) begin
      e_rw = dWEN;
      e_rr = dREN && !dWEN;
      e_a  = daddr;
      e_s  = dstore;
      e_dw = (ramstate != ACCESS);
    end
    if (m_owner == 2 && iREN) begin
      e_rr = 1'b1;
      e_a  = iaddr;
      e_iw = (ramstate != ACCESS);
    end
    chk("iwait", {31'h0, iwait}, {31'h0, e_iw});
    chk("dwait", {31'h0, dwait}, {31'h0, e_dw});
    chk("ramREN", {31'h0, ramREN}, {31'h0, e_rr});
    chk("ramWEN", {31'h0, ramWEN}, {31'h0, e_rw});
    chk("ramaddr", ramaddr, e_a);
    chk("ramstore", ramstore, e_s);
    if (!e_dw) chk("dload", dload, ramload);
    if (!e_iw) chk("iload", iload, ramload);
  endtask

  // apply the edge to the model, then step past the rising edge
  task automatic advance();
    logic dr, done, err;
    dr   = dREN || dWEN;
    done = (ramstate == ACCESS);
    err  = (ramstate == ERROR);
    if (!nRST) begin
      m_owner  = 0;
      m_starve = 0;
    end else begin
      case (m_owner)
        0: begin
          if (m_starve == SMAX && iREN) m_owner = 2;
          else if (dr)                  m_owner = 1;
          else if (iREN)                m_owner = 2;
          else                          m_owner = 0;
        end
        1: begin
          if (!dr || err) m_owner = 0;
          else if (done && iREN) begin
            m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            if (m_starve == SMAX) m_owner = 2;
          end
        end
        2: begin
          if (!iREN || err) m_owner = 0;
          else if (done)    m_starve = 0;
        end
        default: m_owner = 0;
      endcase
      if (!iREN) m_starve = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    ramstate = FREE;
  endtask

  initial begin
    int r;
    nRST = 1'b0;
    ramload = 32'h0;
    idle_inputs();
    @(posedge CLK);
    #1;
    m_owner  = 0;
    m_starve = 0;

    // reset state
    sample();
    chk("rst_iwait", {31'h0, iwait}, 32'h1);
    chk("rst_dwait", {31'h0, dwait}, 32'h1);
    chk("rst_strobes", {30'h0, ramREN, ramWEN}, 32'h0);
    chk("rst_addr", ramaddr, 32'h0);
    chk("rst_store", ramstore, 32'h0);
    advance();
    nRST = 1'b1;
    tick();

    // 1: dcache read, ACCESS two cycles after grant
    dREN = 1'b1; daddr = 32'h40; ramload = 32'hDEAD_0040;
    tick();
    ramstate = BUSY;
    tick();
    tick();
    ramstate = ACCESS;
    sample();
    chk("t1_dwait", {31'h0, dwait}, 32'h0);
    chk("t1_dload", dload, 32'hDEAD_0040);
    chk("t1_iwait", {31'h0, iwait}, 32'h1);
    chk("t1_addr", ramaddr, 32'h40);
    advance();
    idle_inputs();
    tick();
    tick();

    // 2: simultaneous dWEN and iREN: dcache first, icache afterwards
    iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55;
    ramload = 32'h1111_2222;
    tick();
    ramstate = ACCESS;
    sample();
    chk("t2_wen", {31'h0, ramWEN}, 32'h1);
    chk("t2_ren", {31'h0, ramREN}, 32'h0);
    chk("t2_addr", ramaddr, 32'h200);
    chk("t2_store", ramstore, 32'h55);
    advance();
    dWEN = 1'b0; ramstate = FREE;
    tick();
    tick();
    ramstate = ACCESS;
    sample();
    chk("t2_igrant", ramaddr, 32'h100);
    chk("t2_iwait", {31'h0, iwait}, 32'h0);
    advance();
    idle_inputs();
    tick();
    tick();

    // 3: two-word write burst with no ARB gap
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'hA0;
    tick();
    ramstate = ACCESS;
    sample();
    chk("t3_w0_dwait", {31'h0, dwait}, 32'h0);
    chk("t3_w0_addr", ramaddr, 32'h80);
    advance();
    daddr = 32'h84; dstore = 32'hA4;
    sample();
    chk("t3_w1_wen", {31'h0, ramWEN}, 32'h1);
    chk("t3_w1_dwait", {31'h0, dwait}, 32'h0);
    chk("t3_w1_addr", ramaddr, 32'h84);
    advance();
    idle_inputs();
    tick();
    tick();

    // 4: icache forced in after four dcache words
    iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h400;
    tick();
    for (int k = 0; k < 4; k++) begin
      daddr = 32'h400 + 32'(4 * k);
      ramstate = ACCESS;
      sample();
      chk("t4_daddr", ramaddr, 32'h400 + 32'(4 * k));
      chk("t4_dwait", {31'h0, dwait}, 32'h0);
      advance();
    end
    sample();
    chk("t4_iaddr", ramaddr, 32'h300);
    chk("t4_iwait", {31'h0, iwait}, 32'h0);
    chk("t4_dwait_hold", {31'h0, dwait}, 32'h1);
    advance();
    iREN = 1'b0; ramstate = FREE;
    sample();
    chk("t4_idrop", {31'h0, ramREN}, 32'h0);
    advance();
    tick();
    daddr = 32'h410; ramstate = ACCESS;
    sample();
    chk("t4_dback", ramaddr, 32'h410);
    chk("t4_dback_wait", {31'h0, dwait}, 32'h0);
    advance();
    idle_inputs();
    tick();
    tick();

    // 5: ERROR during DGRANT -> retry at the same address
    dREN = 1'b1; daddr = 32'h500;
    tick();
    ramstate = ERROR;
    sample();
    chk("t5_err_dwait", {31'h0, dwait}, 32'h1);
    chk("t5_err_addr", ramaddr, 32'h500);
    advance();
    ramstate = FREE;
    sample();
    chk("t5_arb_ren", {31'h0, ramREN}, 32'h0);
    advance();
    ramstate = ACCESS;
    sample();
    chk("t5_retry_addr", ramaddr, 32'h500);
    chk("t5_retry_dwait", {31'h0, dwait}, 32'h0);
    advance();
    idle_inputs();
    tick();

    // 6: reset during a BUSY icache fetch
    iREN = 1'b1; iaddr = 32'h600;
    tick();
    ramstate = BUSY;
    sample();
    chk("t6_pre_ren", {31'h0, ramREN}, 32'h1);
    nRST = 1'b0;
    advance();
    nRST = 1'b1;
    sample();
    chk("t6_ren", {31'h0, ramREN}, 32'h0);
    chk("t6_iwait", {31'h0, iwait}, 32'h1);
    advance();
    idle_inputs();
    tick();
    tick();

    // randomized traffic with sticky requests
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 15) == 0) iREN = ~iREN;
      if ($urandom_range(0, 7) == 0)  dREN = ~dREN;
      if ($urandom_range(0, 11) == 0) dWEN = ~dWEN;
      if ($urandom_range(0, 3) == 0) begin
        daddr  = $urandom & 32'hFFFF_FFFC;
        iaddr  = $urandom & 32'hFFFF_FFFC;
        dstore = $urandom;
      end
      ramload = $urandom;
      r = $urandom_range(0, 9);
      if (r < 3)      ramstate = BUSY;
      else if (r < 7) ramstate = ACCESS;
      else if (r < 8) ramstate = ERROR;
      else            ramstate = FREE;
      nRST = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
